// File: rtl/rv_core_pkg.sv
// Shared encodings for the multicycle RV32I core: branch flags, instruction
// types, trap causes and the pc_sequencer FSM states.
package rv_core_pkg;

  typedef enum logic [1:0] {
    FLAG_NONE   = 2'b00,
    FLAG_JAL    = 2'b01,
    FLAG_JALR   = 2'b10,
    FLAG_BRANCH = 2'b11
  } flag_branch_e;

  typedef enum logic [2:0] {
    ITYPE_R = 3'd0,
    ITYPE_I = 3'd1,
    ITYPE_S = 3'd2,
    ITYPE_B = 3'd3,
    ITYPE_U = 3'd4,
    ITYPE_J = 3'd5
  } instr_type_e;

  typedef enum logic [1:0] {
    TRAP_NONE     = 2'b00,
    TRAP_MISALIGN = 2'b01,
    TRAP_FETCH_TO = 2'b10
  } trap_cause_e;

  typedef enum logic [1:0] {
    PCS_IDLE  = 2'b00,
    PCS_FETCH = 2'b01,
    PCS_EXEC  = 2'b10,
    PCS_HALT  = 2'b11
  } pcs_state_e;

  localparam logic [31:0] PC_STEP = 32'd4;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/pc_sequencer_next_pc_sel.sv
// Combinational next-PC selection for pc_sequencer, with the word-alignment
// check applied to whichever target is chosen.
module next_pc_sel
  import rv_core_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic [31:0] i_pc_target,
  input  logic [1:0]  i_flag_branch,
  input  logic        i_branch_taken,
  output logic [31:0] o_pc_plus4,
  output logic [31:0] o_next_pc,
  output logic        o_misaligned
);

  flag_branch_e w_flag;

  always_comb begin
    w_flag     = flag_branch_e'(i_flag_branch);
    o_pc_plus4 = i_pc + PC_STEP;
    o_next_pc  = o_pc_plus4;
    case (w_flag)
      FLAG_JAL:    o_next_pc = i_pc_target;
      FLAG_JALR:   o_next_pc = {i_pc_target[31:1], 1'b0};
      FLAG_BRANCH: if (i_branch_taken) o_next_pc = i_pc_target;
      default:     o_next_pc = o_pc_plus4;
    endcase
    // pc is always word aligned, so only a selected target can fault here
    o_misaligned = !is_word_aligned(o_next_pc);
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and fetch sequencer for the multicycle RV32I core.
// Optional retired-instruction counter enabled by `define PC_SEQ_INSTRET_EN.
module pc_sequencer
  import rv_core_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned ACK_TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        exec_done,
  input  logic [31:0] pc_target,
  input  logic [1:0]  flag_branch,
  input  logic        branch_taken,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        trap,
  output logic [1:0]  trap_cause
`ifdef PC_SEQ_INSTRET_EN
  ,
  output logic [63:0] instret
`endif
);

  localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  pcs_state_e       r_state;
  pcs_state_e       w_state_nxt;
  logic [31:0]      r_pc;
  logic [31:0]      r_instr;
  logic             r_instr_valid;
  logic             r_trap;
  trap_cause_e      r_trap_cause;
  logic [CNT_W-1:0] r_cnt;

  logic             w_fetch_ok;
  logic             w_cnt_inc;
  logic             w_commit;
  logic             w_trap_set;
  trap_cause_e      w_trap_cause_nxt;
  logic [31:0]      w_next_pc;
  logic [31:0]      w_pc_plus4;
  logic             w_misaligned;

  next_pc_sel u_next_pc_sel (
    .i_pc           (r_pc),
    .i_pc_target    (pc_target),
    .i_flag_branch  (flag_branch),
    .i_branch_taken (branch_taken),
    .o_pc_plus4     (w_pc_plus4),
    .o_next_pc      (w_next_pc),
    .o_misaligned   (w_misaligned)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= PCS_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_fetch_ok       = 1'b0;
    w_cnt_inc        = 1'b0;
    w_commit         = 1'b0;
    w_trap_set       = 1'b0;
    w_trap_cause_nxt = TRAP_NONE;
    case (r_state)
      PCS_IDLE: w_state_nxt = PCS_FETCH;
      PCS_FETCH: begin
        if (imem_ack) begin
          w_fetch_ok  = 1'b1;
          w_state_nxt = PCS_EXEC;
        end else begin
          w_cnt_inc = 1'b1;
          // the cycle that brings the count to ACK_TIMEOUT is the last one
          if (r_cnt == CNT_LAST) begin
            w_trap_set       = 1'b1;
            w_trap_cause_nxt = TRAP_FETCH_TO;
            w_state_nxt      = PCS_HALT;
          end
        end
      end
      PCS_EXEC: begin
        if (exec_done) begin
          if (w_misaligned) begin
            w_trap_set       = 1'b1;
            w_trap_cause_nxt = TRAP_MISALIGN;
            w_state_nxt      = PCS_HALT;
          end else begin
            w_commit    = 1'b1;
            w_state_nxt = PCS_FETCH;
          end
        end
      end
      PCS_HALT: w_state_nxt = PCS_HALT;
      default:  w_state_nxt = PCS_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc          <= RESET_VECTOR;
      r_instr       <= '0;
      r_instr_valid <= 1'b0;
      r_trap        <= 1'b0;
      r_trap_cause  <= TRAP_NONE;
      r_cnt         <= '0;
    end else begin
      if (w_fetch_ok) begin
        r_instr       <= imem_rdata;
        r_instr_valid <= 1'b1;
      end
      if (w_cnt_inc) r_cnt <= r_cnt + CNT_W'(1);
      if (w_commit) begin
        r_pc          <= w_next_pc;
        r_instr_valid <= 1'b0;
        r_cnt         <= '0;
      end
      if (w_trap_set) begin
        r_trap        <= 1'b1;
        r_trap_cause  <= w_trap_cause_nxt;
        r_instr_valid <= 1'b0;
      end
    end
  end

`ifdef PC_SEQ_INSTRET_EN
  logic [63:0] r_instret;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_instret <= '0;
    else if (w_commit) r_instret <= r_instret + 64'd1;
  end

  assign instret = r_instret;
`endif

  assign imem_req    = (r_state == PCS_FETCH);
  assign imem_addr   = r_pc;
  assign instr       = r_instr;
  assign instr_valid = r_instr_valid;
  assign pc          = r_pc;
  assign pc_plus4    = w_pc_plus4;
  assign trap        = r_trap;
  assign trap_cause  = r_trap_cause;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: stimulus pushes expected fetch addresses
// and trap causes; a negedge monitor pops them as requests/traps appear.
module tb_pc_sequencer;
  import rv_core_pkg::*;

  localparam logic [31:0] RV = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        exec_done;
  logic [31:0] pc_target;
  logic [1:0]  flag_branch;
  logic        branch_taken;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        trap;
  logic [1:0]  trap_cause;
`ifdef PC_SEQ_INSTRET_EN
  logic [63:0] instret;
`endif

  pc_sequencer #(
    .RESET_VECTOR (RV),
    .ACK_TIMEOUT  (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .exec_done    (exec_done),
    .pc_target    (pc_target),
    .flag_branch  (flag_branch),
    .branch_taken (branch_taken),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .trap         (trap),
    .trap_cause   (trap_cause)
`ifdef PC_SEQ_INSTRET_EN
    ,
    .instret      (instret)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_trap;
    logic [31:0] val;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic prev_req  = 1'b0;
  logic prev_trap = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (imem_req && !prev_req) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_req: got addr %0h expected no request", imem_addr);
      end else begin
        e = q.pop_front();
        check("req_kind", {63'd0, e.is_trap}, 64'd0);
        check("fetch_addr", {32'd0, imem_addr}, {32'd0, e.val});
      end
    end
    if (trap && !prev_trap) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_trap: got cause %0h expected no trap", trap_cause);
      end else begin
        e = q.pop_front();
        check("trap_kind", {63'd0, e.is_trap}, 64'd1);
        check("trap_cause", {62'd0, trap_cause}, {62'd0, e.val[1:0]});
        check("trap_req_low", {63'd0, imem_req}, 64'd0);
      end
    end
    prev_req  = imem_req;
    prev_trap = trap;
  end

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (imem_req) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_req: got no imem_req in 50 cycles expected a request");
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    imem_ack = 1'b0;
    exec_done = 1'b0;
    #1;
    check("rst_pc", {32'd0, pc}, {32'd0, RV});
    check("rst_req", {63'd0, imem_req}, 64'd0);
    check("rst_valid", {63'd0, instr_valid}, 64'd0);
    check("rst_instr", {32'd0, instr}, 64'd0);
    check("rst_trap", {62'd0, trap_cause, trap}, 64'd0);
    @(posedge clk);
    #1;
    q.push_back('{1'b0, RV});
    rst = 1'b0;
    imem_ack = 1'b1;
    imem_rdata = 32'hBAD0_0BAD;
    exec_done = 1'b1;
    @(posedge clk);
    #1;
    imem_ack = 1'b0;
    exec_done = 1'b0;
    imem_rdata = '0;
    @(negedge clk);
    check("idle_ack_ignored", {32'd0, instr}, 64'd0);
    check("idle_valid", {63'd0, instr_valid}, 64'd0);
  endtask

  task automatic run_instr(input logic [31:0] cur_pc, input logic [31:0] rdata,
                           input logic [1:0] flag, input logic [31:0] tgt, input logic tk,
                           input logic [31:0] exp_next, input bit exp_trap);
    bit ok;
    logic [31:0] p4;
    p4 = cur_pc + 32'd4;
    wait_req(ok);
    if (!ok) return;
    check("fetch_pc", {32'd0, pc}, {32'd0, cur_pc});
    check("valid_in_fetch", {63'd0, instr_valid}, 64'd0);
    // exec_done alongside ack in FETCH must be ignored
    imem_ack = 1'b1;
    imem_rdata = rdata;
    exec_done = 1'b1;
    flag_branch = FLAG_JAL;
    pc_target = 32'h0000_0444;
    @(posedge clk);
    #1;
    imem_ack = 1'b0;
    exec_done = 1'b0;
    imem_rdata = '0;
    @(negedge clk);
    check("instr", {32'd0, instr}, {32'd0, rdata});
    check("valid_in_exec", {63'd0, instr_valid}, 64'd1);
    check("req_dropped", {63'd0, imem_req}, 64'd0);
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    imem_ack = 1'b0;
    imem_rdata = '0;
    @(negedge clk);
    check("instr_hold", {32'd0, instr}, {32'd0, rdata});
    check("pc_plus4", {32'd0, pc_plus4}, {32'd0, p4});
    flag_branch = flag;
    pc_target = tgt;
    branch_taken = tk;
    exec_done = 1'b1;
    if (exp_trap) q.push_back('{1'b1, 32'(TRAP_MISALIGN)});
    else          q.push_back('{1'b0, exp_next});
    @(posedge clk);
    #1;
    exec_done = 1'b0;
    flag_branch = FLAG_NONE;
    branch_taken = 1'b0;
    @(negedge clk);
    if (exp_trap) begin
      check("trap_pc_held", {32'd0, pc}, {32'd0, cur_pc});
      check("trap_req", {63'd0, imem_req}, 64'd0);
    end else begin
      check("next_pc", {32'd0, pc}, {32'd0, exp_next});
      check("next_req", {63'd0, imem_req}, 64'd1);
    end
    check("valid_cleared", {63'd0, instr_valid}, 64'd0);
  endtask

  task automatic check_halt_holds(input logic [1:0] cause);
    for (int i = 0; i < 4; i++) begin
      imem_ack = 1'b1;
      exec_done = 1'b1;
      @(posedge clk);
      #1;
      imem_ack = 1'b0;
      exec_done = 1'b0;
      @(negedge clk);
      check("halt_req", {63'd0, imem_req}, 64'd0);
      check("halt_valid", {63'd0, instr_valid}, 64'd0);
      check("halt_trap", {61'd0, trap_cause, trap}, {61'd0, cause, 1'b1});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst = 1'b1;
    imem_ack = 1'b0;
    imem_rdata = '0;
    exec_done = 1'b0;
    pc_target = '0;
    flag_branch = FLAG_NONE;
    branch_taken = 1'b0;

    do_reset();
    // pc+4 path with a misaligned target on the bus must not trap
    run_instr(32'h0000_0000, 32'h0000_0013, FLAG_NONE,   32'h0000_0002, 1'b0, 32'h0000_0004, 1'b0);
    run_instr(32'h0000_0004, 32'h1000_0001, FLAG_JAL,    32'h0000_0100, 1'b0, 32'h0000_0100, 1'b0);
    run_instr(32'h0000_0100, 32'h1000_0002, FLAG_JAL,    32'h0000_0200, 1'b0, 32'h0000_0200, 1'b0);
    run_instr(32'h0000_0200, 32'h1000_0003, FLAG_JALR,   32'h0000_0301, 1'b0, 32'h0000_0300, 1'b0);
    run_instr(32'h0000_0300, 32'h1000_0004, FLAG_JAL,    32'h0000_0100, 1'b0, 32'h0000_0100, 1'b0);
    run_instr(32'h0000_0100, 32'h1000_0005, FLAG_BRANCH, 32'h0000_0080, 1'b0, 32'h0000_0104, 1'b0);
    run_instr(32'h0000_0104, 32'h1000_0006, FLAG_JAL,    32'h0000_0100, 1'b0, 32'h0000_0100, 1'b0);
    run_instr(32'h0000_0100, 32'h1000_0007, FLAG_BRANCH, 32'h0000_0080, 1'b1, 32'h0000_0080, 1'b0);
    run_instr(32'h0000_0080, 32'h1000_0008, FLAG_JAL,    32'hFFFF_FFFC, 1'b0, 32'hFFFF_FFFC, 1'b0);
    run_instr(32'hFFFF_FFFC, 32'h1000_0009, FLAG_NONE,   32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0);
    run_instr(32'h0000_0000, 32'h1000_000A, FLAG_JAL,    32'h0000_0100, 1'b0, 32'h0000_0100, 1'b0);
    run_instr(32'h0000_0100, 32'h1000_000B, FLAG_JAL,    32'h0000_0102, 1'b0, 32'h0000_0000, 1'b1);
    check_halt_holds(TRAP_MISALIGN);

    // Fetch timeout: never acknowledge
    do_reset();
    q.push_back('{1'b1, 32'(TRAP_FETCH_TO)});
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!imem_req) break;
      n++;
      @(negedge clk);
    end
    check("timeout_cycles", 64'(n), 64'd4);
    check("timeout_trap", {63'd0, trap}, 64'd1);
    check("timeout_cause", {62'd0, trap_cause}, {62'd0, TRAP_FETCH_TO});
    check_halt_holds(TRAP_FETCH_TO);

    // Reset asserted mid-FETCH at pc=4 takes effect without a clock edge
    do_reset();
    run_instr(32'h0000_0000, 32'h0000_0013, FLAG_NONE, 32'h0000_0000, 1'b0, 32'h0000_0004, 1'b0);
    do_reset();
    run_instr(32'h0000_0000, 32'h2000_0001, FLAG_JALR, 32'h0000_0011, 1'b0, 32'h0000_0010, 1'b0);

    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
